// File: rtl/result_mem_arbiter_pkg.sv
// Shared definitions for the result-memory arbiter and the matrix controller:
// FSM state encodings, default result word / address widths and grant bit slots.
package result_mem_arbiter_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WR   = 2'b01,
        RD   = 2'b10
    } arb_state_t;

    // Bit positions inside the two-bit request / grant vectors
    localparam int GNT_WB = 0;
    localparam int GNT_RD = 1;

endpackage

// File: rtl/result_mem_arbiter_if.sv
// Bus bundle of the result-memory arbiter: ALU write-back port, host read port,
// SRAM port and write-progress status. The arbiter uses the slave modport; the
// requesters/SRAM side (or a bench) uses the master modport.
interface result_mem_arbiter_if #(
    parameter int DATA_W = result_mem_arbiter_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = result_mem_arbiter_pkg::DEFAULT_ADDR_W
);
    logic              clear;
    logic              wb_req;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              mem_csn;
    logic              mem_web;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W:0]   wr_count;
    logic              full;

    modport slave (
        input  clear, wb_req, wb_data, rd_req, rd_addr, mem_rdata,
        output wb_ack, rd_ack, rd_valid, rd_data,
               mem_csn, mem_web, mem_addr, mem_wdata, wr_count, full
    );

    modport master (
        output clear, wb_req, wb_data, rd_req, rd_addr, mem_rdata,
        input  wb_ack, rd_ack, rd_valid, rd_data,
               mem_csn, mem_web, mem_addr, mem_wdata, wr_count, full
    );

endinterface

// File: rtl/result_mem_arbiter_arb_grant.sv
// Grant decision for the result-memory arbiter. Bit 0 is the write-back
// requester, bit 1 the host read. Optional macro ARB_ROUND_ROBIN_EN selects
// alternating grants under contention; otherwise write-back has fixed priority.
module arb_grant
    import result_mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,        // raw requests
    input  logic [1:0] grantable_i,  // requester may be served this cycle
    input  logic       last_rd_i,    // read won the previous contended grant
    output logic [1:0] grant_o       // one-hot (or zero) grant
);

    logic [1:0] elig;

    assign elig = req_i & grantable_i;

`ifdef ARB_ROUND_ROBIN_EN
    // Contention goes to whoever lost the last contended grant
    always_comb begin
        grant_o = elig;
        if (&elig) begin
            grant_o = 2'b00;
            if (last_rd_i) begin
                grant_o[GNT_WB] = 1'b1;
            end else begin
                grant_o[GNT_RD] = 1'b1;
            end
        end
    end
`else
    // The history bit only matters for alternating grants
    logic unused_last_rd;
    assign unused_last_rd = last_rd_i;

    // Write-back wins whenever it is eligible
    always_comb begin
        grant_o = elig;
        if (elig[GNT_WB]) begin
            grant_o = 2'b00;
            grant_o[GNT_WB] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/result_mem_arbiter.sv
// Result-memory arbiter: shares one single-port result SRAM between the ALU
// write-back stream (sequential addresses from a write pointer) and host reads.
// Requests are sampled in one cycle and served in the next, back-to-back.
// Optional macro ARB_ROUND_ROBIN_EN (in arb_grant) alternates contended grants.
module result_mem_arbiter
    import result_mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,   // asynchronous, active-low
    result_mem_arbiter_if.slave  bus
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    arb_state_t        state_q, state_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;  // low bits double as write pointer
    logic              full_q, full_d;
    logic              last_rd_q, last_rd_d;
    logic              mem_csn_q, mem_csn_d;
    logic              mem_web_q, mem_web_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wb_ack_q, rd_ack_q, rd_valid_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic [1:0]        req_vec, grantable, grant;

    // Write count after the coming edge; clear beats the increment of a write in flight
    always_comb begin
        wr_count_d = wr_count_q;
        if (bus.clear) begin
            wr_count_d = '0;
        end else if (state_q == WR) begin
            wr_count_d = wr_count_q + COUNT_ONE;
        end
    end

    // Requests are judged against the post-edge count, so a full or just-cleared
    // memory is seen immediately and the pointer can never wrap
    assign full_d    = (wr_count_d == FULL_COUNT);
    assign req_vec   = {bus.rd_req, bus.wb_req};
    assign grantable = {1'b1, ~full_d};

    arb_grant u_arb_grant (
        .req_i       (req_vec),
        .grantable_i (grantable),
        .last_rd_i   (last_rd_q),
        .grant_o     (grant)
    );

    // Next state and SRAM drive: a grant enters its access state from any state,
    // no grant falls back to IDLE with address/data held
    always_comb begin
        state_d     = IDLE;
        mem_csn_d   = 1'b1;
        mem_web_d   = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        last_rd_d   = last_rd_q;
        if (grant[GNT_WB]) begin
            state_d     = WR;
            mem_csn_d   = 1'b0;
            mem_web_d   = 1'b0;
            mem_addr_d  = wr_count_d[ADDR_W-1:0];
            mem_wdata_d = bus.wb_data;
        end else if (grant[GNT_RD]) begin
            state_d    = RD;
            mem_csn_d  = 1'b0;
            mem_addr_d = bus.rd_addr;
        end
        if (&(req_vec & grantable)) begin
            last_rd_d = grant[GNT_RD];
        end
    end

    // State, registered SRAM port and access acknowledges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_csn_q   <= 1'b1;
            mem_web_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            last_rd_q   <= 1'b1;   // first contended grant goes to the write-back
        end else begin
            state_q     <= state_d;
            mem_csn_q   <= mem_csn_d;
            mem_web_q   <= mem_web_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_ack_q    <= grant[GNT_WB];
            rd_ack_q    <= grant[GNT_RD];
            last_rd_q   <= last_rd_d;
        end
    end

    // Write progress counter and full flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count_q <= '0;
            full_q     <= 1'b0;
        end else begin
            wr_count_q <= wr_count_d;
            full_q     <= full_d;
        end
    end

    // Read return: SRAM data is live in the cycle after RD, then kept in rd_hold_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            rd_valid_q <= (state_q == RD);
            if (rd_valid_q) begin
                rd_hold_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_csn   = mem_csn_q;
    assign bus.mem_web   = mem_web_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.wb_ack    = wb_ack_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_valid_q ? bus.mem_rdata : rd_hold_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.full      = full_q;

endmodule

// File: tb/tb_result_mem_arbiter.sv
// Bench for result_mem_arbiter: SRAM model, transaction-level reference model
// checked every cycle, directed sequences, a contention vector table and
// randomized requesters. Expectations follow macro ARB_ROUND_ROBIN_EN.
module tb_result_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic clk;
    logic rst;

    result_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    result_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- SRAM model (with bench-side preload port) ----------------
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] sram [16];

    always @(posedge clk) begin
        if (pre_en) begin
            sram[pre_addr] <= pre_data;
        end else if (!bus.mem_csn) begin
            if (!bus.mem_web) sram[bus.mem_addr] <= bus.mem_wdata;
            else              bus.mem_rdata <= sram[bus.mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            cnt;     // words written since clear
        bit            w_last;  // write won the last contended grant
        bit            do_w;    // a write is being performed this cycle
        bit            do_r;    // a read is being performed this cycle
        logic [AW-1:0] addr;    // address on the SRAM bus
        logic [DW-1:0] wdata;   // write data on the SRAM bus
        bit            valid;   // read data returned this cycle
        logic [DW-1:0] rdata;   // last read word
    } model_t;

    model_t        m;
    logic [DW-1:0] shadow [16];
    bit            chk_en = 1'b0;

    function automatic model_t model_reset();
        model_t r;
        r.cnt = 0; r.w_last = 1'b0; r.do_w = 1'b0; r.do_r = 1'b0;
        r.addr = '0; r.wdata = '0; r.valid = 1'b0; r.rdata = '0;
        return r;
    endfunction

    function automatic model_t model_next(model_t cur, logic clr, logic wr, logic rr,
                                          logic [AW-1:0] ra, logic [DW-1:0] wd,
                                          logic [DW-1:0] rd_word);
        model_t nx = cur;
        bit w_ok;
        nx.valid = cur.do_r;
        if (cur.do_r) nx.rdata = rd_word;
        nx.cnt  = clr ? 0 : cur.cnt + (cur.do_w ? 1 : 0);
        w_ok    = wr && (nx.cnt < 16);
        nx.do_w = w_ok;
        nx.do_r = rr;
        if (w_ok && rr) begin
`ifdef ARB_ROUND_ROBIN_EN
            nx.do_w = !cur.w_last;
`else
            nx.do_w = 1'b1;
`endif
            nx.do_r   = !nx.do_w;
            nx.w_last = nx.do_w;
        end
        if (nx.do_w) begin
            nx.addr  = AW'(nx.cnt);
            nx.wdata = wd;
        end else if (nx.do_r) begin
            nx.addr = ra;
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= model_reset();
        end else begin
            if (m.do_w)  shadow[m.addr] <= m.wdata;
            if (pre_en)  shadow[pre_addr] <= pre_data;
            m <= model_next(m, bus.clear, bus.wb_req, bus.rd_req, bus.rd_addr,
                            bus.wb_data, shadow[m.addr]);
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("m_wb_ack",   64'(bus.wb_ack),    64'(m.do_w));
            check("m_rd_ack",   64'(bus.rd_ack),    64'(m.do_r));
            check("m_mem_csn",  64'(bus.mem_csn),   64'(!(m.do_w || m.do_r)));
            check("m_mem_web",  64'(bus.mem_web),   64'(!m.do_w));
            check("m_mem_addr", 64'(bus.mem_addr),  64'(m.addr));
            check("m_mem_wdata",64'(bus.mem_wdata), 64'(m.wdata));
            check("m_rd_valid", 64'(bus.rd_valid),  64'(m.valid));
            check("m_rd_data",  64'(bus.rd_data),   64'(m.rdata));
            check("m_wr_count", 64'(bus.wr_count),  64'(m.cnt));
            check("m_full",     64'(bus.full),      64'(m.cnt == 16));
        end
    end

    // ---------------- contention vector table ----------------
    typedef struct {
        logic          w;
        logic          r;
        logic [AW-1:0] ra;
        logic          ew;
        logic          er;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;

`ifdef ARB_ROUND_ROBIN_EN
        tbl[0] = '{1'b1, 1'b1, 4'd1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'd2, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'd4, 1'b0, 1'b1};
`else
        tbl[0] = '{1'b1, 1'b1, 4'd1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'd2, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'd4, 1'b1, 1'b0};
`endif
        tbl[4] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 4'd6, 1'b0, 1'b0};

        rst = 1'b0;
        bus.clear = 1'b0; bus.wb_req = 1'b0; bus.wb_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_csn",  64'(bus.mem_csn),  64'(1));
        check("rst_mem_web",  64'(bus.mem_web),  64'(1));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_wb_ack",   64'(bus.wb_ack),   64'(0));
        check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        check("rst_wr_count", 64'(bus.wr_count), 64'(0));
        check("rst_full",     64'(bus.full),     64'(0));
        rst = 1'b1;
        chk_en = 1'b1;

        // Preload SRAM with known contents, 0xABCD at address 5
        for (int i = 0; i < 16; i++) begin
            pre_en = 1'b1;
            pre_addr = AW'(i);
            pre_data = (i == 5) ? 32'h0000_ABCD : (32'hC0DE_0000 | 32'(i));
            tick();
        end
        pre_en = 1'b0;

        // Single read of address 5
        bus.rd_req = 1'b1; bus.rd_addr = 4'd5;
        tick();
        check("rd_ack_latency", 64'(bus.rd_ack),   64'(1));
        check("rd_mem_addr",    64'(bus.mem_addr), 64'(5));
        bus.rd_req = 1'b0;
        tick();
        check("rd_valid",       64'(bus.rd_valid), 64'(1));
        check("rd_data",        64'(bus.rd_data),  64'(32'hABCD));
        tick();
        check("rd_data_held",   64'(bus.rd_data),  64'(32'hABCD));
        $display("read addr 5 -> %0h", bus.rd_data);

        // Sixteen write-backs fill the matrix, the seventeenth is refused
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.wb_req = 1'b1; bus.wb_data = 32'h10;
        k = 0;
        for (int c = 0; c < 40 && k < 16; c++) begin
            tick();
            if (bus.wb_ack) begin
                check("wb_mem_addr",  64'(bus.mem_addr),  64'(k));
                check("wb_mem_wdata", 64'(bus.mem_wdata), 64'(32'h10 + k));
                $display("write %0d addr %0d data %0h", k, bus.mem_addr, bus.mem_wdata);
                k++;
                bus.wb_data = 32'h10 + 32'(k);
            end
        end
        check("wb_ack_total", 64'(k), 64'(16));
        for (int c = 0; c < 6; c++) begin
            tick();
            check("wb_refused_full", 64'(bus.wb_ack), 64'(0));
        end
        check("full_count", 64'(bus.wr_count), 64'(16));
        check("full_flag",  64'(bus.full),     64'(1));

        // Read while full, with the refused write still pending
        bus.rd_req = 1'b1; bus.rd_addr = 4'd15;
        tick();
        check("full_rd_ack",   64'(bus.rd_ack),   64'(1));
        check("full_rd_addr",  64'(bus.mem_addr), 64'(15));
        bus.rd_req = 1'b0; bus.wb_req = 1'b0;
        tick();
        check("full_rd_data",  64'(bus.rd_data),  64'(32'h1F));
        check("full_rd_count", 64'(bus.wr_count), 64'(16));
        $display("read addr 15 while full -> %0h", bus.rd_data);

        // Clear coinciding with the write at count 7
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear_count", 64'(bus.wr_count), 64'(0));
        check("clear_full",  64'(bus.full),     64'(0));
        bus.wb_req = 1'b1; bus.wb_data = 32'h100;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (bus.wb_ack) begin
                if (bus.mem_addr == 4'd7) begin
                    check("clr_cnt_at_7", 64'(bus.wr_count), 64'(7));
                    bus.clear = 1'b1;
                    bus.wb_data = 32'h55;
                    seen = 1'b1;
                end else begin
                    bus.wb_data = bus.wb_data + 32'h1;
                end
            end
        end
        check("clr_reached_7", 64'(seen), 64'(1));
        tick();
        bus.clear = 1'b0;
        check("clr_count_0", 64'(bus.wr_count),  64'(0));
        check("clr_wb_ack",  64'(bus.wb_ack),    64'(1));
        check("clr_addr_0",  64'(bus.mem_addr),  64'(0));
        check("clr_wdata",   64'(bus.mem_wdata), 64'(32'h55));
        bus.wb_req = 1'b0;
        tick();
        check("clr_count_1", 64'(bus.wr_count),  64'(1));
        $display("clear at count 7 -> next write addr 0");

        // Reset asserted in the middle of a read access
        bus.rd_req = 1'b1; bus.rd_addr = 4'd3;
        tick();
        check("rstrd_in_rd", 64'(bus.mem_csn), 64'(0));
        #2;
        rst = 1'b0;
        bus.rd_req = 1'b0;
        #1;
        check("rstrd_csn",      64'(bus.mem_csn),   64'(1));
        check("rstrd_web",      64'(bus.mem_web),   64'(1));
        check("rstrd_addr",     64'(bus.mem_addr),  64'(0));
        check("rstrd_wdata",    64'(bus.mem_wdata), 64'(0));
        check("rstrd_rd_ack",   64'(bus.rd_ack),    64'(0));
        check("rstrd_rd_data",  64'(bus.rd_data),   64'(0));
        check("rstrd_count",    64'(bus.wr_count),  64'(0));
        tick();
        check("rstrd_no_valid", 64'(bus.rd_valid),  64'(0));
        check("rstrd_csn_held", 64'(bus.mem_csn),   64'(1));
        rst = 1'b1;
        tick();
        $display("reset during read aborted the access");

        // Contention table, starting from the fresh post-reset arbitration state
        for (int i = 0; i < 6; i++) begin
            bus.wb_req  = tbl[i].w;
            bus.rd_req  = tbl[i].r;
            bus.rd_addr = tbl[i].ra;
            bus.wb_data = 32'h200 + 32'(i);
            tick();
            check("tbl_wb_ack",  64'(bus.wb_ack),  64'(tbl[i].ew));
            check("tbl_rd_ack",  64'(bus.rd_ack),  64'(tbl[i].er));
            check("tbl_mem_csn", 64'(bus.mem_csn), 64'(!(tbl[i].ew || tbl[i].er)));
            $display("row %0d wb_req=%0b rd_req=%0b -> wb_ack=%0b rd_ack=%0b",
                     i, tbl[i].w, tbl[i].r, bus.wb_ack, bus.rd_ack);
        end
        bus.wb_req = 1'b0; bus.rd_req = 1'b0;
        tick();

        // Randomized requesters that hold each request until acknowledged
        for (int c = 0; c < 600; c++) begin
            if (bus.wb_req && bus.wb_ack) begin
                bus.wb_req  = ($urandom_range(0, 1) == 1);
                bus.wb_data = $urandom;
            end else if (!bus.wb_req && $urandom_range(0, 2) == 0) begin
                bus.wb_req  = 1'b1;
                bus.wb_data = $urandom;
            end
            if (bus.rd_req && bus.rd_ack) begin
                bus.rd_req  = ($urandom_range(0, 1) == 1);
                bus.rd_addr = AW'($urandom_range(0, 15));
            end else if (!bus.rd_req && $urandom_range(0, 2) == 0) begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = AW'($urandom_range(0, 15));
            end
            bus.clear = ($urandom_range(0, 49) == 0);
            tick();
        end
        bus.wb_req = 1'b0; bus.rd_req = 1'b0; bus.clear = 1'b0;
        repeat (3) tick();
        $display("random phase done, %0d words counted", bus.wr_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
